// File: rtl/nbbsoc_pkg.sv
// nbbsoc_pkg: shared constants for the MMIO SoC slice.
//   IO_BASE      - data address[15:12] value that selects the IO region
//   REG_*        - IO register offsets on address[1:0]
//   opcode_e     - nbbpu instruction opcodes (instr = {op, rd, ra/imm})
//   instr_ri/rr  - instruction encoders used by the program ROM
package nbbsoc_pkg;

  localparam logic [3:0] IO_BASE     = 4'hF;
  localparam logic [1:0] REG_LED     = 2'd0;
  localparam logic [1:0] REG_BUTTONS = 2'd1;
  localparam logic [1:0] REG_TIMER   = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,  // rd = {8'h00, imm8}
    OP_LHI = 4'h2,  // rd[15:8] = imm8
    OP_ST  = 4'h3,  // mem[ra] = rd
    OP_LD  = 4'h4,  // rd = mem[ra]
    OP_JMP = 4'h5   // pc = imm8
  } opcode_e;

  function automatic logic [15:0] instr_ri(opcode_e op, logic [3:0] rd, logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [15:0] instr_rr(opcode_e op, logic [3:0] rd, logic [3:0] ra);
    return {op, rd, ra, 4'h0};
  endfunction

endpackage

// File: rtl/nbbpu.sv
// nbbpu: minimal single-cycle 16-bit CPU, 16 registers, 8-bit PC.
//   clock, reset (active high, async) | instruction in, pc out
//   data_addr/write_data/write_enable out, read_data in (combinational memory)
module nbbpu import nbbsoc_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  output logic [7:0]  pc,
  output logic [15:0] data_addr,
  output logic [15:0] write_data,
  output logic        write_enable,
  input  logic [15:0] read_data
);
  opcode_e     op;
  logic [3:0]  rd, ra;
  logic [7:0]  imm;
  logic [15:0] regs [16];

  assign op           = opcode_e'(instruction[15:12]);
  assign rd           = instruction[11:8];
  assign ra           = instruction[7:4];
  assign imm          = instruction[7:0];
  assign data_addr    = regs[ra];
  assign write_data   = regs[rd];
  // No stores may leak out while the core is held in reset.
  assign write_enable = (op == OP_ST) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      pc <= (op == OP_JMP) ? imm : pc + 8'd1;
      case (op)
        OP_LDI:  regs[rd]       <= {8'h00, imm};
        OP_LHI:  regs[rd][15:8] <= imm;
        OP_LD:   regs[rd]       <= read_data;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/nbbsoc_io.sv
// nbbsoc_io: MMIO peripheral registers.
//   clock, reset (active low, async)
//   buttons      - async pushbutton levels in; buttons_sync - 2-flop synchronized
//   write_enable - any CPU write (drives blink); io_sel/reg_addr - IO decode
//   led_wdata    - LED slice of write data; leds - LED register
//   timer/overflow - 16-bit prescaled counter and sticky wrap flag
//   blink        - registered, high while the write-activity stretcher runs
module nbbsoc_io import nbbsoc_pkg::*; #(
  parameter int NUM_LEDS     = 8,
  parameter int NUM_BUTTONS  = 4,
  parameter int BLINK_CYCLES = 1000000,
  parameter int TIMER_DIV    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   write_enable,
  input  logic                   io_sel,
  input  logic [1:0]             reg_addr,
  input  logic [NUM_LEDS-1:0]    led_wdata,
  output logic [NUM_LEDS-1:0]    leds,
  output logic [NUM_BUTTONS-1:0] buttons_sync,
  output logic [15:0]            timer,
  output logic                   overflow,
  output logic                   blink
);
  localparam logic [15:0] PRESC_MAX  = 16'(TIMER_DIV - 1);
  localparam logic [23:0] BLINK_LOAD = 24'(BLINK_CYCLES);

  logic [NUM_BUTTONS-1:0] btn_meta;
  logic [15:0]            presc;
  logic [23:0]            blink_cnt, blink_cnt_nxt;
  logic                   led_we, timer_clr, tick;

  assign led_we    = write_enable && io_sel && (reg_addr == REG_LED);
  assign timer_clr = write_enable && io_sel && (reg_addr == REG_TIMER);
  assign tick      = (presc == PRESC_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      leds <= '0;
    else if (led_we) leds <= led_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta     <= '0;
      buttons_sync <= '0;
    end else begin
      btn_meta     <= buttons;
      buttons_sync <= btn_meta;
    end
  end

  // Clear has priority over tick and wrap so software always sees a clean restart.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc    <= '0;
      timer    <= '0;
      overflow <= 1'b0;
    end else if (timer_clr) begin
      presc    <= '0;
      timer    <= '0;
      overflow <= 1'b0;
    end else if (tick) begin
      presc <= '0;
      timer <= timer + 16'd1;
      if (timer == 16'hFFFF) overflow <= 1'b1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_comb begin
    blink_cnt_nxt = blink_cnt;
    if (write_enable)          blink_cnt_nxt = BLINK_LOAD;
    else if (blink_cnt != '0)  blink_cnt_nxt = blink_cnt - 24'd1;
  end

  // blink tracks the counter value being loaded, so it is a clean flop output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink     <= (blink_cnt_nxt != '0);
    end
  end
endmodule

// File: rtl/ram.sv
// ram: 4K x 16 data memory, combinational read, synchronous write.
//   clock, reset (active high; blocks writes) | addr, write_data, write_enable, read_data
module ram (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] addr,
  input  logic [15:0] write_data,
  input  logic        write_enable,
  output logic [15:0] read_data
);
  logic [15:0] mem [4096];

  always_ff @(posedge clock) begin
    if (write_enable && !reset) mem[addr] <= write_data;
  end

  assign read_data = mem[addr];
endmodule

// File: rtl/rom.sv
// rom: instruction memory addressed by PC, combinational read.
//   addr - PC; data - instruction word. Holds the bring-up program that
//   exercises RAM, LED, BUTTONS, TIMER and STATUS, then parks on a self-jump.
module rom import nbbsoc_pkg::*; (
  input  logic [7:0]  addr,
  output logic [15:0] data
);
  always_comb begin
    data = instr_ri(OP_NOP, 4'd0, 8'h00);
    case (addr)
      8'd0:  data = instr_ri(OP_LDI, 4'd1, 8'h34);
      8'd1:  data = instr_ri(OP_LHI, 4'd1, 8'h12);   // r1 = 1234
      8'd2:  data = instr_ri(OP_LDI, 4'd2, 8'h00);   // r2 = 0000 (RAM)
      8'd3:  data = instr_rr(OP_ST,  4'd1, 4'd2);    // RAM[0] = 1234
      8'd4:  data = instr_ri(OP_LDI, 4'd3, 8'h00);
      8'd5:  data = instr_ri(OP_LHI, 4'd3, 8'hF0);   // r3 = F000 (LED)
      8'd6:  data = instr_ri(OP_LDI, 4'd4, 8'hA5);
      8'd10: data = instr_rr(OP_ST,  4'd4, 4'd3);    // LED = A5
      8'd11: data = instr_rr(OP_LD,  4'd5, 4'd3);    // r5 = LED
      8'd12: data = instr_rr(OP_LD,  4'd6, 4'd2);    // r6 = RAM[0]
      8'd13: data = instr_rr(OP_ST,  4'd4, 4'd3);    // second write, restarts blink
      8'd14: data = instr_ri(OP_LDI, 4'd7, 8'h01);
      8'd15: data = instr_ri(OP_LHI, 4'd7, 8'hF0);   // r7 = F001 (BUTTONS)
      8'd16: data = instr_rr(OP_LD,  4'd8, 4'd7);
      8'd17: data = instr_ri(OP_LDI, 4'd9, 8'h02);
      8'd18: data = instr_ri(OP_LHI, 4'd9, 8'hF0);   // r9 = F002 (TIMER)
      8'd19: data = instr_rr(OP_ST,  4'd9, 4'd9);    // clear TIMER
      8'd20: data = instr_rr(OP_LD,  4'd10, 4'd9);
      8'd24: data = instr_rr(OP_LD,  4'd11, 4'd9);
      8'd25: data = instr_ri(OP_LDI, 4'd12, 8'h03);
      8'd26: data = instr_ri(OP_LHI, 4'd12, 8'hF0);  // r12 = F003 (STATUS)
      8'd27: data = instr_rr(OP_LD,  4'd13, 4'd12);
      8'd28: data = instr_ri(OP_JMP, 4'd0, 8'd28);
      default: ;
    endcase
  end
endmodule

// File: rtl/nbbsoc_mmio.sv
// nbbsoc_mmio: SoC top - nbbpu + rom + ram with a memory-mapped IO region.
//   clock, reset (active low, async)
//   buttons - async pushbutton levels; leds - LED register; blink - write activity
// Addresses with [15:12]==IO_BASE hit the IO registers (offset on [1:0],
// [11:2] ignored); everything else goes to RAM.
module nbbsoc_mmio import nbbsoc_pkg::*; #(
  parameter int NUM_LEDS     = 8,
  parameter int NUM_BUTTONS  = 4,
  parameter int BLINK_CYCLES = 1000000,
  parameter int TIMER_DIV    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_LEDS-1:0]    leds,
  output logic                   blink
);
  logic [1:0]             rst_pipe;
  logic                   cpu_reset;
  logic [7:0]             pc;
  logic [15:0]            instruction, data_addr, write_data, read_data;
  logic [15:0]            ram_rdata, io_rdata, io_timer;
  logic                   write_enable, io_sel, ram_we, io_overflow;
  logic [NUM_BUTTONS-1:0] io_buttons;

  // Core reset: asserts with the pin, releases two edges after it rises.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_pipe <= 2'b11;
    else        rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign cpu_reset = rst_pipe[1];

  assign io_sel = (data_addr[15:12] == IO_BASE);
  assign ram_we = write_enable && !io_sel;

  nbbpu u_cpu (
    .clock(clock), .reset(cpu_reset), .instruction(instruction), .pc(pc),
    .data_addr(data_addr), .write_data(write_data),
    .write_enable(write_enable), .read_data(read_data)
  );

  rom u_rom (.addr(pc), .data(instruction));

  ram u_ram (
    .clock(clock), .reset(cpu_reset), .addr(data_addr[11:0]),
    .write_data(write_data), .write_enable(ram_we), .read_data(ram_rdata)
  );

  nbbsoc_io #(
    .NUM_LEDS(NUM_LEDS), .NUM_BUTTONS(NUM_BUTTONS),
    .BLINK_CYCLES(BLINK_CYCLES), .TIMER_DIV(TIMER_DIV)
  ) u_io (
    .clock(clock), .reset(reset), .buttons(buttons),
    .write_enable(write_enable), .io_sel(io_sel), .reg_addr(data_addr[1:0]),
    .led_wdata(write_data[NUM_LEDS-1:0]), .leds(leds), .buttons_sync(io_buttons),
    .timer(io_timer), .overflow(io_overflow), .blink(blink)
  );

  always_comb begin
    io_rdata = '0;
    case (data_addr[1:0])
      REG_LED:     io_rdata = 16'(leds);
      REG_BUTTONS: io_rdata = 16'(io_buttons);
      REG_TIMER:   io_rdata = io_timer;
      REG_STATUS:  io_rdata = {15'd0, io_overflow};
    endcase
  end

  assign read_data = io_sel ? io_rdata : ram_rdata;
endmodule

// File: tb/tb_nbbsoc_mmio.sv
// Directed bench: the SoC top runs its ROM program (BLINK_CYCLES=5,
// TIMER_DIV=4); E<n> below is the n-th rising edge after reset release, and
// ROM word k commits at E(3+k). Two stand-alone nbbsoc_io instances
// (TIMER_DIV=1) cover synchronizer latency, async reset abort and the
// 16-bit wrap / clear-vs-wrap collision within a short run.
module tb_nbbsoc_mmio;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic [7:0] leds;
  logic       blink;
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  nbbsoc_mmio #(.NUM_LEDS(8), .NUM_BUTTONS(4), .BLINK_CYCLES(5), .TIMER_DIV(4)) dut (
    .clock(clock), .reset(reset), .buttons(buttons), .leds(leds), .blink(blink)
  );

  logic        a_rst_n, a_we, a_sel, b_we, b_sel;
  logic [1:0]  a_addr, b_addr;
  logic [3:0]  a_btn, a_btn_sync, b_btn_sync;
  logic [7:0]  a_led, a_leds, b_leds;
  logic [15:0] a_timer, b_timer;
  logic        a_ovf, b_ovf, a_blink, b_blink;

  nbbsoc_io #(.NUM_LEDS(8), .NUM_BUTTONS(4), .BLINK_CYCLES(5), .TIMER_DIV(1)) io_a (
    .clock(clock), .reset(a_rst_n), .buttons(a_btn), .write_enable(a_we), .io_sel(a_sel),
    .reg_addr(a_addr), .led_wdata(a_led), .leds(a_leds), .buttons_sync(a_btn_sync),
    .timer(a_timer), .overflow(a_ovf), .blink(a_blink)
  );

  nbbsoc_io #(.NUM_LEDS(8), .NUM_BUTTONS(4), .BLINK_CYCLES(5), .TIMER_DIV(1)) io_b (
    .clock(clock), .reset(a_rst_n), .buttons(a_btn), .write_enable(b_we), .io_sel(b_sel),
    .reg_addr(b_addr), .led_wdata(a_led), .leds(b_leds), .buttons_sync(b_btn_sync),
    .timer(b_timer), .overflow(b_ovf), .blink(b_blink)
  );

  task automatic test_reset();
    reset = 1'b0; a_rst_n = 1'b0; buttons = 4'b1010; a_btn = 4'b0000;
    a_we = 1'b0; a_sel = 1'b0; a_addr = 2'd0; a_led = 8'h00;
    b_we = 1'b0; b_sel = 1'b0; b_addr = 2'd2;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h want 00", leds); end
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink: got %b want 0", blink); end
    checks++; if (dut.cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_held: got %b want 1", dut.cpu_reset); end
    checks++; if ({a_timer, b_leds, b_btn_sync, b_blink} !== 29'd0) begin errors++; $display("FAIL reset_io: got %h want 0", {a_timer, b_leds, b_btn_sync, b_blink}); end
    @(negedge clock);
    reset = 1'b1; a_rst_n = 1'b1;
    @(posedge clock); #1;  // E1
    checks++; if (dut.cpu_reset !== 1'b1) begin errors++; $display("FAIL cpu_reset_e1: got %b want 1", dut.cpu_reset); end
    @(posedge clock); #1;  // E2
    checks++; if (dut.cpu_reset !== 1'b0) begin errors++; $display("FAIL cpu_reset_e2: got %b want 0", dut.cpu_reset); end
    checks++; if (dut.pc !== 8'd0) begin errors++; $display("FAIL pc_e2: got %0d want 0", dut.pc); end
  endtask

  // RAM write commits at E6; nothing else is written until E13.
  task automatic test_blink_single();
    for (int e = 3; e <= 12; e++) begin
      @(posedge clock); #1;
      checks++;
      if (blink !== (e >= 6 && e <= 10)) begin errors++; $display("FAIL blink_single_e%0d: got %b want %b", e, blink, (e >= 6 && e <= 10)); end
      if (e == 6) begin
        checks++; if (dut.u_ram.mem[0] !== 16'h1234) begin errors++; $display("FAIL ram_write: got %h want 1234", dut.u_ram.mem[0]); end
      end
      if (e == 12) begin
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL led_before_write: got %h want 00", leds); end
      end
    end
  endtask

  task automatic test_led_write();
    @(posedge clock); #1;  // E13: write F000 <= 00A5
    checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_write: got %h want a5", leds); end
    @(posedge clock); #1;  // E14: r5 <= [F000]
    checks++; if (dut.u_cpu.regs[5] !== 16'h00A5) begin errors++; $display("FAIL led_readback: got %h want 00a5", dut.u_cpu.regs[5]); end
    @(posedge clock); #1;  // E15: r6 <= RAM[0]
    checks++; if (dut.u_cpu.regs[6] !== 16'h1234) begin errors++; $display("FAIL ram_untouched_read: got %h want 1234", dut.u_cpu.regs[6]); end
    checks++; if (dut.u_ram.mem[0] !== 16'h1234) begin errors++; $display("FAIL ram_untouched_mem: got %h want 1234", dut.u_ram.mem[0]); end
  endtask

  // Second LED write at E16 restarts the stretcher: high through E20.
  task automatic test_blink_restart();
    for (int e = 16; e <= 21; e++) begin
      @(posedge clock); #1;
      checks++;
      if (blink !== (e <= 20)) begin errors++; $display("FAIL blink_restart_e%0d: got %b want %b", e, blink, (e <= 20)); end
    end
  endtask

  // Ticks at E4,8,...,20 -> 5 at E21; clear at E22 resets prescaler so next tick is E26.
  task automatic test_timer_prescale();
    checks++; if (dut.io_timer !== 16'd5) begin errors++; $display("FAIL timer_e21: got %0d want 5", dut.io_timer); end
    @(posedge clock); #1;  // E22
    checks++; if (dut.io_timer !== 16'd0) begin errors++; $display("FAIL timer_clear: got %0d want 0", dut.io_timer); end
    @(posedge clock); #1;  // E23
    checks++; if (dut.u_cpu.regs[10] !== 16'h0000) begin errors++; $display("FAIL timer_read0: got %h want 0000", dut.u_cpu.regs[10]); end
    repeat (2) @(posedge clock); #1;  // E25
    checks++; if (dut.io_timer !== 16'd0) begin errors++; $display("FAIL timer_e25: got %0d want 0", dut.io_timer); end
    @(posedge clock); #1;  // E26
    checks++; if (dut.io_timer !== 16'd1) begin errors++; $display("FAIL timer_e26: got %0d want 1", dut.io_timer); end
    @(posedge clock); #1;  // E27
    checks++; if (dut.u_cpu.regs[11] !== 16'h0001) begin errors++; $display("FAIL timer_read1: got %h want 0001", dut.u_cpu.regs[11]); end
    repeat (3) @(posedge clock); #1;  // E30
    checks++; if (dut.u_cpu.regs[13] !== 16'h0000) begin errors++; $display("FAIL status_read: got %h want 0000", dut.u_cpu.regs[13]); end
  endtask

  task automatic test_buttons_read();
    checks++; if (dut.u_cpu.regs[8] !== 16'h000A) begin errors++; $display("FAIL buttons_read: got %h want 000a", dut.u_cpu.regs[8]); end
  endtask

  task automatic test_buttons_sync();
    @(negedge clock); a_btn = 4'b1010;
    @(posedge clock); #1;
    checks++; if (a_btn_sync !== 4'b0000) begin errors++; $display("FAIL btn_sync_1edge: got %b want 0000", a_btn_sync); end
    @(posedge clock); #1;
    checks++; if (a_btn_sync !== 4'b1010) begin errors++; $display("FAIL btn_sync_2edge: got %b want 1010", a_btn_sync); end
  endtask

  task automatic test_io_reset_abort();
    @(negedge clock); a_sel = 1'b1; a_addr = 2'd0; a_led = 8'h5A; a_we = 1'b1;
    @(posedge clock); #1;
    a_we = 1'b0; a_sel = 1'b0;
    checks++; if (a_leds !== 8'h5A) begin errors++; $display("FAIL io_led: got %h want 5a", a_leds); end
    @(posedge clock); #1;
    checks++; if (a_blink !== 1'b1) begin errors++; $display("FAIL io_blink_run: got %b want 1", a_blink); end
    #2 a_rst_n = 1'b0;
    #1;
    checks++; if ({a_leds, a_blink, a_timer, a_btn_sync, a_ovf} !== 30'd0) begin errors++; $display("FAIL io_async_reset: got %h want 0", {a_leds, a_blink, a_timer, a_btn_sync, a_ovf}); end
    @(posedge clock);
    @(negedge clock); a_rst_n = 1'b1;
    @(posedge clock); #1;
    checks++; if (a_timer !== 16'd1 || b_timer !== 16'd1) begin errors++; $display("FAIL io_restart_timer: got %h/%h want 0001", a_timer, b_timer); end
    checks++; if (a_blink !== 1'b0) begin errors++; $display("FAIL io_restart_blink: got %b want 0", a_blink); end
  endtask

  // io_b is written on the very edge where it ticks and wraps; io_a wraps freely.
  task automatic test_timer_wrap();
    repeat (65534) @(posedge clock);
    #1;
    checks++; if (a_timer !== 16'hFFFF || b_timer !== 16'hFFFF || a_ovf !== 1'b0) begin errors++; $display("FAIL wrap_pre: got %h/%h ovf %b want ffff/ffff ovf 0", a_timer, b_timer, a_ovf); end
    b_sel = 1'b1; b_we = 1'b1;
    @(posedge clock); #1;
    b_we = 1'b0; b_sel = 1'b0;
    checks++; if (a_timer !== 16'h0000 || a_ovf !== 1'b1) begin errors++; $display("FAIL wrap: got %h ovf %b want 0000 ovf 1", a_timer, a_ovf); end
    checks++; if (b_timer !== 16'h0000 || b_ovf !== 1'b0) begin errors++; $display("FAIL clear_vs_wrap: got %h ovf %b want 0000 ovf 0", b_timer, b_ovf); end
    @(posedge clock); #1;
    checks++; if (a_timer !== 16'h0001 || a_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %h ovf %b want 0001 ovf 1", a_timer, a_ovf); end
    checks++; if (b_timer !== 16'h0001 || b_ovf !== 1'b0) begin errors++; $display("FAIL collision_after: got %h ovf %b want 0001 ovf 0", b_timer, b_ovf); end
  endtask

  task automatic test_timer_clear();
    a_sel = 1'b1; a_addr = 2'd2; a_we = 1'b1;
    @(posedge clock); #1;
    a_we = 1'b0; a_sel = 1'b0;
    checks++; if (a_timer !== 16'h0000 || a_ovf !== 1'b0) begin errors++; $display("FAIL timer_write_clear: got %h ovf %b want 0000 ovf 0", a_timer, a_ovf); end
  endtask

  initial begin
    test_reset();
    test_blink_single();
    test_led_write();
    test_blink_restart();
    test_timer_prescale();
    test_buttons_read();
    test_buttons_sync();
    test_io_reset_abort();
    test_timer_wrap();
    test_timer_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
